// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu : instruction fetch unit
//
// Holds the program counter. Issues one fetch at a time to instruction RAM and
// keeps the returned word, with its PC, on a valid/ready output for the decode
// stage. Redirects from the execute stage change the PC, and any fetch already
// on the wrong path is dropped.
//
// Ports
//   i_sys_clk, i_sys_rst_n    clock; synchronous active-low reset
//   o_ifu_ram_req/_addr       fetch request and address (address = PC)
//   i_ram_gnt                 RAM accepted the request this cycle
//   i_ram_rsp_valid/i_ram_inst  returned instruction word
//   o_sys_valid/i_sys_ready   handshake to decode for the held instruction
//   o_ifu_inst/o_ifu_pc       held instruction and its PC
//   i_exu_jmp_en/_pc          redirect pulse and target
//   o_ifu_misalign            one-cycle pulse: redirect target was not word aligned
//   o_ifu_dbg_state           current FSM state, for observation
//
// Handshake: a transfer to decode happens on a rising edge where
// o_sys_valid=1 and i_sys_ready=1. Once raised, o_sys_valid and the held
// instruction/PC stay stable until that transfer. The only exceptions are a
// redirect or a reset, which drop the held word.
// ----------------------------------------------------------------------------
module ifu #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VEC = 32'h8000_0000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  output logic                  o_ifu_ram_req,
  output logic [DATA_WIDTH-1:0] o_ifu_ram_addr,
  input  logic                  i_ram_gnt,
  input  logic                  i_ram_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_ram_inst,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  output logic [DATA_WIDTH-1:0] o_ifu_pc,
  input  logic                  i_exu_jmp_en,
  input  logic [DATA_WIDTH-1:0] i_exu_jmp_pc,
  output logic                  o_ifu_misalign,
  output logic [1:0]            o_ifu_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic                    kill_q, kill_d;
  logic                    misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0]   jmp_target;

  // Redirect targets are always forced to word alignment.
  assign jmp_target = {i_exu_jmp_pc[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      inst_q     <= '0;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    kill_d     = kill_q;
    misalign_d = i_exu_jmp_en && (i_exu_jmp_pc[1:0] != 2'b00);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // A redirect on the grant cycle means the word now in flight is
        // from the old path and must be dropped when it returns.
        if (i_ram_gnt) begin
          state_d = ST_WAIT;
          kill_d  = i_exu_jmp_en;
        end
      end
      ST_WAIT: begin
        if (i_ram_rsp_valid) begin
          if (kill_q || i_exu_jmp_en) begin
            kill_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            inst_d  = i_ram_inst;
            state_d = ST_HOLD;
          end
        end else if (i_exu_jmp_en) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // A redirect takes priority over the handoff, so there is no
        // transfer and no increment.
        if (i_exu_jmp_en) begin
          state_d = ST_FETCH;
        end else if (i_sys_ready) begin
          pc_d    = pc_q + DATA_WIDTH'(4);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_exu_jmp_en) begin
      pc_d = jmp_target;
    end
  end

  assign o_ifu_ram_req   = (state_q == ST_FETCH);
  assign o_ifu_ram_addr  = pc_q;
  assign o_sys_valid     = (state_q == ST_HOLD);
  assign o_ifu_inst      = inst_q;
  assign o_ifu_pc        = pc_q;
  assign o_ifu_misalign  = misalign_q;
  assign o_ifu_dbg_state = state_q;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        misalign;
  logic [1:0]  dbg_state;

  int vecs = 0;
  int errs = 0;

  ifu dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .o_ifu_ram_req   (req),
    .o_ifu_ram_addr  (addr),
    .i_ram_gnt       (gnt),
    .i_ram_rsp_valid (rsp_valid),
    .i_ram_inst      (rsp_inst),
    .o_sys_valid     (valid),
    .i_sys_ready     (ready),
    .o_ifu_inst      (inst),
    .o_ifu_pc        (pc),
    .i_exu_jmp_en    (jmp_en),
    .i_exu_jmp_pc    (jmp_pc),
    .o_ifu_misalign  (misalign),
    .o_ifu_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    gnt = 1'b0; rsp_valid = 1'b0; rsp_inst = '0;
    ready = 1'b0; jmp_en = 1'b0; jmp_pc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    if (req !== 1'b0) begin errs++; $display("FAIL rst_req got=%0b exp=0", req); end vecs++;
    if (valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%0b exp=0", valid); end vecs++;
    if (misalign !== 1'b0) begin errs++; $display("FAIL rst_misalign got=%0b exp=0", misalign); end vecs++;
    if (addr !== 32'h8000_0000) begin errs++; $display("FAIL rst_addr got=%h exp=80000000", addr); end vecs++;
    if (pc !== 32'h8000_0000) begin errs++; $display("FAIL rst_pc got=%h exp=80000000", pc); end vecs++;
    if (inst !== 32'h0) begin errs++; $display("FAIL rst_inst got=%h exp=0", inst); end vecs++;
    if (dbg_state !== 2'd0) begin errs++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end vecs++;
    rst_n = 1'b1;
    tick();   // IDLE -> FETCH
  endtask

  // Scenario 1: single fetch with a one-cycle RAM, immediate handoff.
  task automatic test_basic_fetch();
    if (req !== 1'b1 || addr !== 32'h8000_0000) begin errs++; $display("FAIL t1_req got=%0b/%h exp=1/80000000", req, addr); end vecs++;
    gnt = 1'b1;
    tick();   // WAIT
    gnt = 1'b0;
    if (req !== 1'b0 || valid !== 1'b0) begin errs++; $display("FAIL t1_wait got req=%0b valid=%0b exp=0/0", req, valid); end vecs++;
    rsp_valid = 1'b1; rsp_inst = 32'h0000_a0b7;
    tick();   // HOLD
    rsp_valid = 1'b0;
    if (valid !== 1'b1 || inst !== 32'h0000_a0b7 || pc !== 32'h8000_0000) begin
      errs++; $display("FAIL t1_hold got=%0b/%h/%h exp=1/0000a0b7/80000000", valid, inst, pc); end vecs++;
    ready = 1'b1;
    tick();   // FETCH
    ready = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0004) begin
      errs++; $display("FAIL t1_next got=%0b/%0b/%h exp=0/1/80000004", valid, req, addr); end vecs++;
  endtask

  // Scenario 2: decode stalls for 5 cycles while an instruction is held.
  task automatic test_backpressure();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h1234_5013;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (valid !== 1'b1 || inst !== 32'h1234_5013 || pc !== 32'h8000_0004 || req !== 1'b0) begin
        errs++; $display("FAIL t2_stall%0d got=%0b/%h/%h/%0b exp=1/12345013/80000004/0", i, valid, inst, pc, req); end vecs++;
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (valid !== 1'b0 || addr !== 32'h8000_0008) begin
      errs++; $display("FAIL t2_handoff got=%0b/%h exp=0/80000008", valid, addr); end vecs++;
    tick();   // no grant: stays in FETCH, pc must not move again
    if (req !== 1'b1 || addr !== 32'h8000_0008) begin
      errs++; $display("FAIL t2_once got=%0b/%h exp=1/80000008", req, addr); end vecs++;
  endtask

  // Scenario 3: redirect while waiting for a response.
  task automatic test_redirect_wait();
    gnt = 1'b1;
    tick();   // WAIT
    gnt = 1'b0; jmp_en = 1'b1; jmp_pc = 32'h8000_0100;
    tick();   // still WAIT, kill set
    jmp_en = 1'b0;
    if (valid !== 1'b0 || req !== 1'b0 || misalign !== 1'b0) begin
      errs++; $display("FAIL t3_wait got=%0b/%0b/%0b exp=0/0/0", valid, req, misalign); end vecs++;
    rsp_valid = 1'b1; rsp_inst = 32'h00a0_00ef;
    tick();   // word dropped -> FETCH
    rsp_valid = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0100) begin
      errs++; $display("FAIL t3_drop got=%0b/%0b/%h exp=0/1/80000100", valid, req, addr); end vecs++;
    tick();
    if (valid !== 1'b0) begin errs++; $display("FAIL t3_never got=%0b exp=0", valid); end vecs++;
  endtask

  // Scenario 4: redirect in HOLD with ready asserted the same cycle.
  task automatic test_redirect_hold();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0000_0013;
    tick();
    rsp_valid = 1'b0;
    if (valid !== 1'b1 || pc !== 32'h8000_0100) begin
      errs++; $display("FAIL t4_hold got=%0b/%h exp=1/80000100", valid, pc); end vecs++;
    ready = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h8000_0200;
    tick();
    ready = 1'b0; jmp_en = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0200) begin
      errs++; $display("FAIL t4_redir got=%0b/%0b/%h exp=0/1/80000200", valid, req, addr); end vecs++;
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0040_0093;
    tick();
    rsp_valid = 1'b0;
    if (valid !== 1'b1 || inst !== 32'h0040_0093 || pc !== 32'h8000_0200) begin
      errs++; $display("FAIL t4_target got=%0b/%h/%h exp=1/00400093/80000200", valid, inst, pc); end vecs++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (addr !== 32'h8000_0204) begin errs++; $display("FAIL t4_next got=%h exp=80000204", addr); end vecs++;
  endtask

  // Scenario 5: misaligned redirect target.
  task automatic test_misalign();
    jmp_en = 1'b1; jmp_pc = 32'h8000_0102;
    tick();
    jmp_en = 1'b0;
    if (misalign !== 1'b1 || req !== 1'b1 || addr !== 32'h8000_0100) begin
      errs++; $display("FAIL t5_pulse got=%0b/%0b/%h exp=1/1/80000100", misalign, req, addr); end vecs++;
    tick();
    if (misalign !== 1'b0 || addr !== 32'h8000_0100) begin
      errs++; $display("FAIL t5_clear got=%0b/%h exp=0/80000100", misalign, addr); end vecs++;
  endtask

  // Redirect on the grant cycle, and redirect coinciding with the response.
  task automatic test_redirect_edges();
    gnt = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h8000_0300;
    tick();   // WAIT with kill
    gnt = 1'b0; jmp_en = 1'b0;
    rsp_valid = 1'b1; rsp_inst = 32'hdead_beef;
    tick();
    rsp_valid = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0300) begin
      errs++; $display("FAIL tr_gnt got=%0b/%0b/%h exp=0/1/80000300", valid, req, addr); end vecs++;
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'hcafe_f00d; jmp_en = 1'b1; jmp_pc = 32'h8000_0400;
    tick();
    rsp_valid = 1'b0; jmp_en = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0400) begin
      errs++; $display("FAIL tr_rsp got=%0b/%0b/%h exp=0/1/80000400", valid, req, addr); end vecs++;
    // The kill flag must not linger: the next word is delivered normally.
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0000_0011;
    tick();
    rsp_valid = 1'b0;
    if (valid !== 1'b1 || inst !== 32'h0000_0011 || pc !== 32'h8000_0400) begin
      errs++; $display("FAIL tr_clean got=%0b/%h/%h exp=1/00000011/80000400", valid, inst, pc); end vecs++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Scenario 6: long grant stall, PC wraparound, reset during WAIT.
  task automatic test_stall_wrap_reset();
    for (int i = 0; i < 10; i++) begin
      if (req !== 1'b1 || addr !== 32'h8000_0404) begin
        errs++; $display("FAIL t6_stall%0d got=%0b/%h exp=1/80000404", i, req, addr); end vecs++;
      tick();
    end
    jmp_en = 1'b1; jmp_pc = 32'hffff_fffc;
    tick();
    jmp_en = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0000_0073;
    tick();
    rsp_valid = 1'b0;
    if (valid !== 1'b1 || pc !== 32'hffff_fffc) begin
      errs++; $display("FAIL t6_top got=%0b/%h exp=1/fffffffc", valid, pc); end vecs++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (req !== 1'b1 || addr !== 32'h0000_0000) begin
      errs++; $display("FAIL t6_wrap got=%0b/%h exp=1/00000000", req, addr); end vecs++;
    gnt = 1'b1;
    tick();   // WAIT
    gnt = 1'b0; rst_n = 1'b0;
    tick();   // back to reset state
    rst_n = 1'b1;
    if (req !== 1'b0 || valid !== 1'b0 || addr !== 32'h8000_0000) begin
      errs++; $display("FAIL t6_rst got=%0b/%0b/%h exp=0/0/80000000", req, valid, addr); end vecs++;
    rsp_valid = 1'b1; rsp_inst = 32'h0bad_0bad;
    tick();   // late response arrives in IDLE
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8000_0000) begin
      errs++; $display("FAIL t6_late got=%0b/%0b/%h exp=0/1/80000000", valid, req, addr); end vecs++;
    tick();   // still present in FETCH, also ignored
    rsp_valid = 1'b0;
    if (valid !== 1'b0 || req !== 1'b1 || dbg_state !== 2'd1) begin
      errs++; $display("FAIL t6_fetch got=%0b/%0b/%0d exp=0/1/1", valid, req, dbg_state); end vecs++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_redirect_edges();
    test_stall_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
